// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator.
//   formato_t : instruction format code driven on formato_o
//   OP_*      : RV32/RV64 base opcodes (instr[6:0]) recognised by the decoder
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } formato_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/decodificador_formato.sv
// Combinational opcode classifier.
//   opcode   : instr[6:0]
//   formato  : instruction format (FMT_NONE for unknown opcodes)
//   illegal  : unknown opcode, only when FLAG_ILLEGAL is set
module decodificador_formato
    import imm_pkg::*;
#(
    parameter bit FLAG_ILLEGAL = 1'b1
) (
    input  logic [6:0] opcode,
    output formato_t   formato,
    output logic       illegal
);

    always_comb begin
        formato = FMT_NONE;
        unique case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: formato = FMT_I;
            OP_STORE:                            formato = FMT_S;
            OP_BRANCH:                           formato = FMT_B;
            OP_LUI, OP_AUIPC:                    formato = FMT_U;
            OP_JAL:                              formato = FMT_J;
            OP_REG:                              formato = FMT_R;
            default:                             formato = FMT_NONE;
        endcase
    end

    assign illegal = FLAG_ILLEGAL && (formato == FMT_NONE);

endmodule

// File: rtl/generador_inmediatos.sv
// Two-stage pipelined RISC-V immediate generator.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   flush_i                : kills every in-flight entry at the next edge
//   valid_i/ready_o        : instruction input handshake (instruccion_i)
//   valid_o/ready_i        : result output handshake
//   inmediato_o            : sign-extended immediate, XLEN bits (32 or 64)
//   formato_o              : format code R=0 I=1 S=2 B=3 U=4 J=5 NONE=7
//   illegal_o              : unknown opcode (tied low when FLAG_ILLEGAL=0)
// Stage A registers the instruction and its decoded format; stage B
// registers the assembled immediate. Outputs come straight from stage B.
module generador_inmediatos
    import imm_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FLAG_ILLEGAL = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instruccion_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] inmediato_o,
    output logic [2:0]      formato_o,
    output logic            illegal_o
);

    // Handshake: a transfer happens on an edge where valid and ready are
    // both high. A producer holding valid keeps its data stable until the
    // transfer; ready may depend combinationally on the consumer's ready.
    // Stage A advances into B whenever B is empty or being drained, so
    // accepts and drains overlap without a bubble.

    logic        v_a, v_b;
    logic [31:7] instr_a;            // opcode bits are consumed by the decoder
    formato_t    formato_a, formato_b;
    logic        illegal_a, illegal_b;
    logic [XLEN-1:0] imm_b;

    formato_t    formato_dec;
    logic        illegal_dec;

    logic        adv_b, move_a, accept;
    logic signed [31:0] imm32;

    decodificador_formato #(
        .FLAG_ILLEGAL (FLAG_ILLEGAL)
    ) u_decodificador (
        .opcode  (instruccion_i[6:0]),
        .formato (formato_dec),
        .illegal (illegal_dec)
    );

    assign adv_b   = v_b & ready_i;
    assign move_a  = v_a & (~v_b | ready_i);
    assign ready_o = ~v_a | move_a;
    assign accept  = valid_i & ready_o;

    // All formats place the sign in bit 31, so a 32-bit signed result
    // widened with a sign-extending cast covers both XLEN values.
    always_comb begin
        imm32 = '0;
        unique case (formato_a)
            FMT_I:   imm32 = {{20{instr_a[31]}}, instr_a[31:20]};
            FMT_S:   imm32 = {{20{instr_a[31]}}, instr_a[31:25], instr_a[11:7]};
            FMT_B:   imm32 = {{20{instr_a[31]}}, instr_a[7], instr_a[30:25],
                              instr_a[11:8], 1'b0};
            FMT_U:   imm32 = {instr_a[31:12], 12'b0};
            FMT_J:   imm32 = {{12{instr_a[31]}}, instr_a[19:12], instr_a[20],
                              instr_a[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_a       <= 1'b0;
            instr_a   <= '0;
            formato_a <= FMT_NONE;
            illegal_a <= 1'b0;
        end else begin
            if (flush_i)     v_a <= 1'b0;
            else if (accept) v_a <= 1'b1;
            else if (move_a) v_a <= 1'b0;

            if (accept) begin
                instr_a   <= instruccion_i[31:7];
                formato_a <= formato_dec;
                illegal_a <= illegal_dec;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_b       <= 1'b0;
            imm_b     <= '0;
            formato_b <= FMT_NONE;
            illegal_b <= 1'b0;
        end else begin
            if (flush_i)     v_b <= 1'b0;
            else if (move_a) v_b <= 1'b1;
            else if (adv_b)  v_b <= 1'b0;

            if (move_a) begin
                imm_b     <= XLEN'(imm32);
                formato_b <= formato_a;
                illegal_b <= illegal_a;
            end
        end
    end

    assign valid_o     = v_b;
    assign inmediato_o = imm_b;
    assign formato_o   = formato_b;
    assign illegal_o   = illegal_b;

endmodule

// File: tb/tb_generador_inmediatos.sv
module tb_generador_inmediatos;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] instr;

    // three instances: XLEN=32 flagged, XLEN=64 flagged, XLEN=32 unflagged
    logic        rdy_a, vo_a, ill_a;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic        rdy_b, vo_b, ill_b;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
    logic        rdy_c, vo_c, ill_c;
    logic [31:0] imm_c;
    logic [2:0]  fmt_c;

    generador_inmediatos #(.XLEN(32), .FLAG_ILLEGAL(1'b1)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in),
        .ready_o(rdy_a), .instruccion_i(instr), .valid_o(vo_a), .ready_i(ready_in),
        .inmediato_o(imm_a), .formato_o(fmt_a), .illegal_o(ill_a));

    generador_inmediatos #(.XLEN(64), .FLAG_ILLEGAL(1'b1)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in),
        .ready_o(rdy_b), .instruccion_i(instr), .valid_o(vo_b), .ready_i(ready_in),
        .inmediato_o(imm_b), .formato_o(fmt_b), .illegal_o(ill_b));

    generador_inmediatos #(.XLEN(32), .FLAG_ILLEGAL(1'b0)) dut_noflag (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in),
        .ready_o(rdy_c), .instruccion_i(instr), .valid_o(vo_c), .ready_i(ready_in),
        .inmediato_o(imm_c), .formato_o(fmt_c), .illegal_o(ill_c));

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Immediate value computed as an integer from the instruction fields.
    function automatic void ref_imm(input logic [31:0] i, output longint imm,
                                    output int fmt, output bit ill);
        longint hi;
        hi  = i[31] ? 64'sd1 : 64'sd0;
        imm = 0;
        fmt = 7;
        ill = 1'b1;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin
                fmt = 1; ill = 1'b0;
                imm = longint'(i[31:20]) - hi * 4096;
            end
            7'h23: begin
                fmt = 2; ill = 1'b0;
                imm = longint'(i[31:25]) * 32 + longint'(i[11:7]) - hi * 4096;
            end
            7'h63: begin
                fmt = 3; ill = 1'b0;
                imm = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                    + longint'(i[11:8]) * 2 - hi * 4096;
            end
            7'h37, 7'h17: begin
                fmt = 4; ill = 1'b0;
                imm = longint'(i[31:12]) * 4096 - hi * 64'sh1_0000_0000;
            end
            7'h6F: begin
                fmt = 5; ill = 1'b0;
                imm = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                    + longint'(i[30:21]) * 2 - hi * 1048576;
            end
            7'h33: begin
                fmt = 0; ill = 1'b0;
            end
            default: ;
        endcase
    endfunction

    // Scoreboard: instructions in flight, oldest first. An entry becomes
    // visible at the output once it has lived through one clock edge and
    // is the oldest one.
    logic [31:0] exp_q[$];
    bit          aged_q[$];

    function automatic bit exp_valid();
        return (exp_q.size() > 0) && aged_q[0];
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_valid32"}, 64'(vo_a), 64'd0);
        check({tag, "_valid64"}, 64'(vo_b), 64'd0);
        check({tag, "_validnf"}, 64'(vo_c), 64'd0);
        check({tag, "_imm32"},   64'(imm_a), 64'd0);
        check({tag, "_imm64"},   imm_b, 64'd0);
        check({tag, "_fmt"},     64'(fmt_a), 64'd7);
        check({tag, "_fmt64"},   64'(fmt_b), 64'd7);
        check({tag, "_ill"},     64'(ill_a), 64'd0);
    endtask

    // ---------------- driver ----------------
    // One clock cycle: check outputs, drive inputs, check ready, update model.
    task automatic cycle(input logic v, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        bit          ev, er, acc;
        longint      imm;
        int          fmt;
        bit          ill;
        @(negedge clk);
        ev = exp_valid();
        check("valid_o32", 64'(vo_a), 64'(ev));
        check("valid_o64", 64'(vo_b), 64'(ev));
        check("valid_onf", 64'(vo_c), 64'(ev));
        if (ev) begin
            ref_imm(exp_q[0], imm, fmt, ill);
            check("imm32",  64'(imm_a), {32'd0, imm[31:0]});
            check("fmt32",  64'(fmt_a), 64'(fmt));
            check("ill32",  64'(ill_a), 64'(ill));
            check("imm64",  imm_b,      64'(imm));
            check("fmt64",  64'(fmt_b), 64'(fmt));
            check("immnf",  64'(imm_c), {32'd0, imm[31:0]});
            check("illnf",  64'(ill_c), 64'd0);
        end
        valid_in = v;
        instr    = ins;
        ready_in = rdy;
        flush    = fl;
        #1;
        er = (exp_q.size() < 2) || rdy;
        check("ready_o32", 64'(rdy_a), 64'(er));
        check("ready_o64", 64'(rdy_b), 64'(er));
        check("ready_onf", 64'(rdy_c), 64'(er));
        acc = v && er;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            aged_q.delete();
        end else begin
            if (ev && rdy) begin
                void'(exp_q.pop_front());
                void'(aged_q.pop_front());
            end
            foreach (aged_q[k]) aged_q[k] = 1'b1;
            if (acc) begin
                exp_q.push_back(ins);
                aged_q.push_back(1'b0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] opcodes [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        instr    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // back-to-back I, S, B
        cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        cycle(1'b1, 32'hFE112E23, 1'b1, 1'b0);
        cycle(1'b1, 32'hFE000CE3, 1'b1, 1'b0);
        idle(3);

        // U then J
        cycle(1'b1, 32'h123450B7, 1'b1, 1'b0);
        cycle(1'b1, 32'h0010006F, 1'b1, 1'b0);
        idle(3);

        // backpressure: third offer waits until ready_i returns
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200113, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 32'h00300193, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300193, 1'b1, 1'b0);
        idle(4);

        // unknown opcode
        cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
        idle(3);

        // flush with two entries in flight, then a fresh instruction
        cycle(1'b1, 32'h00A00093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00B00093, 1'b0, 1'b0);
        cycle(1'b0, 32'h0,        1'b1, 1'b1);
        cycle(1'b1, 32'h00500093, 1'b1, 1'b0);
        idle(3);

        // flush wins over a simultaneous accept
        cycle(1'b1, 32'h00700093, 1'b1, 1'b0);
        cycle(1'b1, 32'h00800093, 1'b1, 1'b1);
        idle(3);

        // negative U immediate (64-bit sign extension)
        cycle(1'b1, 32'h800000B7, 1'b1, 1'b0);
        idle(3);

        // asynchronous reset while stalled
        cycle(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        cycle(1'b1, 32'h123450B7, 1'b0, 1'b0);
        cycle(1'b0, 32'h0,        1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        check("midreset_ready", 64'(rdy_a), 64'd1);
        exp_q.delete();
        aged_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r = $urandom();
            if ($urandom_range(0, 9) != 0)
                r[6:0] = opcodes[$urandom_range(0, 10)];
            cycle(1'($urandom_range(0, 3) != 0), r,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 29) == 0));
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/generador_inmediatos.md
Name: generador_inmediatos

Overview:
Pipelined immediate generator for the single-cycle/pipelined RISC-V core.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Classifies the instruction format and produces the sign-extended immediate at XLEN width.
- Successor to the combinational I/S/Load-only extender: covers all base formats (I, S, B, U, J), is parametrised in XLEN, supports backpressure and flush, and flags unknown opcodes.

Parameters:
- XLEN, 32, output immediate width. Legal values are 32 and 64.
- FLAG_ILLEGAL, 1, when 1, unknown opcodes assert illegal_o. When 0, illegal_o is tied to 0.

Ports:
- clk_i, input, 1, clock.
- rst_ni, input, 1, reset, asynchronous, active-low.
- flush_i, input, 1, synchronous kill of all in-flight entries.
- valid_i, input, 1, instruction_i is valid.
- ready_o, output, 1, block can accept this cycle.
- instruccion_i, input, 32, raw instruction.
- valid_o, output, 1, result is valid.
- ready_i, input, 1, consumer accepts this cycle.
- inmediato_o, output, XLEN, sign-extended immediate.
- formato_o, output, 3, format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- illegal_o, output, 1, opcode not recognised.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
  - In reset, all valid bits clear, so valid_o=0.
  - inmediato_o=0, formato_o=7, illegal_o=0.
  - ready_o=1 immediately after reset deasserts.
- Pipeline: two register stages, A (decode) and B (build).
  - Stage A holds vA, the instruction and the format.
  - Stage B holds vB, the immediate, the format and the illegal flag.
  - Outputs come directly from stage B registers.
- Handshake:
  - advB = vB & ready_i.
  - moveA = vA & (!vB | ready_i).
  - ready_o = !vA | moveA.
  - Accept occurs when valid_i & ready_o.
  - Latency: an instruction accepted at edge N appears on valid_o after edge N+1, i.e. 2 cycles.
  - Throughput: 1 per cycle when ready_i=1.
  - Stage B outputs hold stable while valid_o & !ready_i.
  - valid_o never drops without a handshake, except on flush or reset.
- Opcode decode (instr[6:0]):
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → R.
  - Anything else → NONE, with illegal=FLAG_ILLEGAL.
- Immediate build (sx = sign-extend bit 31 to XLEN):
  - I: sx(i[31:20]).
  - S: sx({i[31:25],i[11:7]}).
  - B: sx({i[31],i[7],i[30:25],i[11:8],1'b0}).
  - U: sx({i[31:12],12'b0}). For XLEN=64, bits 63:32 = i[31].
  - J: sx({i[31],i[19:12],i[20],i[30:21],1'b0}).
  - R and NONE: 0.
- Flush:
  - flush_i=1 clears vA and vB at the next edge.
  - An input offered in the same cycle is accepted but discarded, so flush wins.
  - ready_o is unaffected.
- Simultaneous events:
  - Accept while stage B drains: A→B and input→A move in the same edge with no bubble.
  - Reset mid-stall: all data is dropped. No partial output.
- Data registers update only on their stage's load enable. This avoids X-propagation from idle inputs.

Decomposition:
- Package imm_pkg holds:
  - the formato_t enum (R, I, S, B, U, J, NONE);
  - opcode localparams (OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG).
- One combinational sub-module, decodificador_formato: instr[6:0] → {formato, illegal}, instantiated before stage A.
- Immediate assembly is inline in stage B.

Test Plan:
- XLEN=32, ready_i=1. Send 0xFFF00093 (addi -1), then 0xFE112E23 (sw -4), then 0xFE000CE3 (beq -8) back-to-back.
  → Outputs appear on consecutive cycles starting 2 cycles after the first accept: 0xFFFFFFFF/I, 0xFFFFFFFC/S, 0xFFFFFFF8/B.
- Send 0x123450B7 (lui), then 0x0010006F (jal +2048).
  → 0x12345000/U, then 0x00000800/J. illegal_o=0.
- Hold ready_i=0 and offer 3 instructions.
  → Two are accepted. ready_o=0 on the third. valid_o is held with stable data.
  → After ready_i=1, all three emerge in order with no loss or duplication.
- Send 0x0000007F.
  → inmediato_o=0, formato_o=7, illegal_o=1. With FLAG_ILLEGAL=0, illegal_o=0.
- Pulse flush_i with 2 entries in flight.
  → valid_o=0 next cycle. The next accepted instruction (0x00500093) yields 0x00000005/I.
- XLEN=64, send 0x800000B7.
  → 0xFFFFFFFF80000000/U.
- Assert rst_ni=0 mid-stall.
  → valid_o=0 immediately, and outputs read reset values.
